// File: rtl/uart_cmd_decoder_if.sv
// Receive handshake and register-write bus between the UART receiver side and uart_cmd_decoder.
// The decoder uses the slave modport; the byte source / register sink side uses master.
interface uart_cmd_decoder_if;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_error;
  logic        rx_read;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;
  logic [7:0]  err_count;
  logic        busy;

  modport slave (
    input  rx_data,
    input  rx_ready,
    input  rx_error,
    output rx_read,
    output wr_en,
    output wr_addr,
    output wr_data,
    output frame_err,
    output err_count,
    output busy
  );

  modport master (
    output rx_data,
    output rx_ready,
    output rx_error,
    input  rx_read,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  frame_err,
    input  err_count,
    input  busy
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Assembles HDR/ADDR/DATA_H/DATA_L[/CHK] frames from the UART receiver into register-write strobes.
// Define UART_CMD_CHECKSUM_EN to add the trailing XOR checksum byte (5-byte frames).
module uart_cmd_decoder #(
  parameter int unsigned C_CLK_FRQ    = 100000000,
  parameter int unsigned C_TIMEOUT_US = 1000,
  parameter logic [7:0]  C_HEADER     = 8'hA5
) (
  input logic                clk,
  input logic                rstb,
  uart_cmd_decoder_if.slave  bus
);

  localparam int unsigned C_TO = (C_CLK_FRQ / 1000000) * C_TIMEOUT_US;
  localparam int unsigned TW   = $clog2(C_TO + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(C_TO);

`ifdef UART_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {
    StHdr, StAddr, StDh, StDl, StChk, StWrite, StErr
  } state_e;
`else
  typedef enum logic [2:0] {
    StHdr, StAddr, StDh, StDl, StWrite, StErr
  } state_e;
`endif

  state_e          state_q, state_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      dh_q, dh_d;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]      dl_q, dl_d;
`endif
  logic            rx_read_q;
  logic            wr_en_q, wr_en_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic [15:0]     wr_data_q, wr_data_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      err_count_q, err_count_d;
  logic            busy_q, busy_d;

  logic receiving;
  logic consume;
  logic byte_ok;
  logic byte_bad;
  logic timeout;

  // Consumption is blocked while the previous acknowledge is still high.
  assign receiving = (state_q != StWrite) && (state_q != StErr);
  assign consume   = receiving && bus.rx_ready && !rx_read_q;
  assign byte_ok   = consume && !bus.rx_error;
  assign byte_bad  = consume && bus.rx_error;
  assign timeout   = (to_cnt_q == TO_LIM) && (state_q != StHdr);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dh_d      = dh_q;
`ifdef UART_CMD_CHECKSUM_EN
    dl_d      = dl_q;
`endif
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (byte_bad) begin
      state_d = StErr;
    end else begin
      unique case (state_q)
        StHdr: begin
          if (byte_ok && (bus.rx_data == C_HEADER)) state_d = StAddr;
        end
        StAddr: begin
          if (byte_ok) begin
            addr_d  = bus.rx_data;
            state_d = StDh;
          end else if (timeout) begin
            state_d = StErr;
          end
        end
        StDh: begin
          if (byte_ok) begin
            dh_d    = bus.rx_data;
            state_d = StDl;
          end else if (timeout) begin
            state_d = StErr;
          end
        end
        StDl: begin
          if (byte_ok) begin
`ifdef UART_CMD_CHECKSUM_EN
            dl_d      = bus.rx_data;
            state_d   = StChk;
`else
            wr_addr_d = addr_q;
            wr_data_d = {dh_q, bus.rx_data};
            state_d   = StWrite;
`endif
          end else if (timeout) begin
            state_d = StErr;
          end
        end
`ifdef UART_CMD_CHECKSUM_EN
        StChk: begin
          if (byte_ok) begin
            if (bus.rx_data == (addr_q ^ dh_q ^ dl_q)) begin
              wr_addr_d = addr_q;
              wr_data_d = {dh_q, dl_q};
              state_d   = StWrite;
            end else begin
              state_d   = StErr;
            end
          end else if (timeout) begin
            state_d = StErr;
          end
        end
`endif
        StWrite: state_d = StHdr;
        StErr:   state_d = StHdr;
        default: state_d = StHdr;
      endcase
    end

    to_cnt_d    = ((state_q == StHdr) || consume) ? '0 : to_cnt_q + TW'(1);
    wr_en_d     = (state_d == StWrite);
    frame_err_d = (state_d == StErr);
    err_count_d = err_count_q;
    if ((state_d == StErr) && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    busy_d      = (state_d != StHdr);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= StHdr;
      to_cnt_q    <= '0;
      addr_q      <= 8'h00;
      dh_q        <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
      dl_q        <= 8'h00;
`endif
      rx_read_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 16'h0000;
      frame_err_q <= 1'b0;
      err_count_q <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      addr_q      <= addr_d;
      dh_q        <= dh_d;
`ifdef UART_CMD_CHECKSUM_EN
      dl_q        <= dl_d;
`endif
      rx_read_q   <= consume;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rx_read   = rx_read_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_count = err_count_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder; timeout shortened to 100 cycles (1 us at 100 MHz).
// Frame length follows UART_CMD_CHECKSUM_EN exactly as the design does.
module tb_uart_cmd_decoder;
  localparam int unsigned CTO = 100;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  uart_cmd_decoder_if bus ();

  uart_cmd_decoder #(
    .C_CLK_FRQ    (100000000),
    .C_TIMEOUT_US (1),
    .C_HEADER     (8'hA5)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int ferr_cnt = 0;
  int exp_err;
  int exp_wr;
  int exp_ferr;
  logic w;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) wr_cnt++;
    if (bus.frame_err === 1'b1) ferr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte, wait for the acknowledge, then drop rx_ready on the next edge.
  task automatic send_byte(input logic [7:0] d, input logic e, output logic wr_seen);
    logic got;
    got = 1'b0;
    bus.rx_data  = d;
    bus.rx_error = e;
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 16 && !got; i++) begin
      @(posedge clk);
      #1;
      if (bus.rx_read === 1'b1) got = 1'b1;
    end
    wr_seen = bus.wr_en;
    chk("read_ack", got, 1'b1);
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b0;
    bus.rx_error = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl,
                            output logic wr_seen);
    logic s;
    send_byte(8'hA5, 1'b0, s);
    send_byte(a, 1'b0, s);
    send_byte(dh, 1'b0, s);
    send_byte(dl, 1'b0, s);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(a ^ dh ^ dl, 1'b0, s);
`endif
    wr_seen = s;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_ready = 1'b0;
    bus.rx_error = 1'b0;
    rstb = 1'b0;
    idle(3);
    chk("rst_rx_read", bus.rx_read, 1'b0);
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_wr_addr", bus.wr_addr, 8'h00);
    chk("rst_wr_data", bus.wr_data, 16'h0000);
    chk("rst_frame_err", bus.frame_err, 1'b0);
    chk("rst_err_count", bus.err_count, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    rstb = 1'b1;
    idle(2);
    exp_err = 0;
    exp_wr = 0;
    exp_ferr = 0;

    // Valid frame; wr_en must be up in the cycle after the last byte is taken.
    send_frame(8'h03, 8'h12, 8'h34, w);
    exp_wr++;
    chk("f1_wr_en_timing", w, 1'b1);
    idle(4);
    chk("f1_wr_cnt", wr_cnt, exp_wr);
    chk("f1_wr_addr", bus.wr_addr, 8'h03);
    chk("f1_wr_data", bus.wr_data, 16'h1234);
    chk("f1_err_count", bus.err_count, exp_err);
    chk("f1_busy_idle", bus.busy, 1'b0);

`ifdef UART_CMD_CHECKSUM_EN
    // 09^55^66 = 3A; send 3B instead.
    send_byte(8'hA5, 1'b0, w);
    send_byte(8'h09, 1'b0, w);
    send_byte(8'h55, 1'b0, w);
    send_byte(8'h66, 1'b0, w);
    send_byte(8'h3B, 1'b0, w);
    exp_err++;
    exp_ferr++;
    idle(4);
    chk("badchk_wr_cnt", wr_cnt, exp_wr);
    chk("badchk_ferr", ferr_cnt, exp_ferr);
    chk("badchk_err_count", bus.err_count, exp_err);
    chk("badchk_wr_addr", bus.wr_addr, 8'h03);
    chk("badchk_wr_data", bus.wr_data, 16'h1234);
`endif

    // Garbage ahead of a header is dropped silently.
    send_byte(8'h00, 1'b0, w);
    send_byte(8'hFF, 1'b0, w);
    idle(2);
    chk("resync_busy", bus.busy, 1'b0);
    chk("resync_ferr", ferr_cnt, exp_ferr);
    send_frame(8'h07, 8'hAB, 8'hCD, w);
    exp_wr++;
    idle(4);
    chk("resync_wr_cnt", wr_cnt, exp_wr);
    chk("resync_wr_addr", bus.wr_addr, 8'h07);
    chk("resync_wr_data", bus.wr_data, 16'hABCD);
    chk("resync_err_count", bus.err_count, exp_err);

    // Timeout: ADDR taken at edge N, abort decided at edge N+CTO+1.
    send_byte(8'hA5, 1'b0, w);
    send_byte(8'h01, 1'b0, w);
    idle(CTO - 1);
    chk("to_busy_before", bus.busy, 1'b1);
    chk("to_ferr_before", bus.frame_err, 1'b0);
    idle(1);
    chk("to_ferr_at_limit", bus.frame_err, 1'b1);
    exp_err++;
    exp_ferr++;
    idle(9);
    chk("to_busy_after", bus.busy, 1'b0);
    chk("to_err_count", bus.err_count, exp_err);
    chk("to_wr_cnt", wr_cnt, exp_wr);
    send_frame(8'h11, 8'h22, 8'h33, w);
    exp_wr++;
    idle(4);
    chk("to_next_wr_addr", bus.wr_addr, 8'h11);
    chk("to_next_wr_data", bus.wr_data, 16'h2233);

    // Receiver error on DATA_H.
    send_byte(8'hA5, 1'b0, w);
    send_byte(8'h04, 1'b0, w);
    send_byte(8'h99, 1'b1, w);
    exp_err++;
    exp_ferr++;
    idle(4);
    chk("rxerr_ferr", ferr_cnt, exp_ferr);
    chk("rxerr_err_count", bus.err_count, exp_err);
    chk("rxerr_wr_cnt", wr_cnt, exp_wr);
    chk("rxerr_wr_addr", bus.wr_addr, 8'h11);

    // Errored bytes in the idle state each count; the counter saturates.
    for (int i = 0; i < 300; i++) send_byte(8'h00, 1'b1, w);
    exp_ferr += 300;
    exp_err = (exp_err + 300 > 255) ? 255 : exp_err + 300;
    idle(4);
    chk("sat_err_count", bus.err_count, exp_err);
    chk("sat_ferr", ferr_cnt, exp_ferr);

    // Asynchronous reset in the middle of a frame.
    send_byte(8'hA5, 1'b0, w);
    send_byte(8'h02, 1'b0, w);
    #2;
    rstb = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_err_count", bus.err_count, 8'h00);
    chk("mid_rst_wr_addr", bus.wr_addr, 8'h00);
    chk("mid_rst_wr_data", bus.wr_data, 16'h0000);
    chk("mid_rst_rx_read", bus.rx_read, 1'b0);
    chk("mid_rst_frame_err", bus.frame_err, 1'b0);
    idle(2);
    rstb = 1'b1;
    idle(2);
    chk("mid_rst_wr_cnt", wr_cnt, exp_wr);
    send_frame(8'h0A, 8'hBE, 8'hEF, w);
    exp_wr++;
    idle(4);
    chk("post_rst_wr_cnt", wr_cnt, exp_wr);
    chk("post_rst_wr_addr", bus.wr_addr, 8'h0A);
    chk("post_rst_wr_data", bus.wr_data, 16'hBEEF);
    chk("post_rst_err_count", bus.err_count, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
